// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: owns PC/IF-ID enables, IF/ID flush and ID/EX bubble.
// Handles load-use stalls, taken-branch flushes and fixed-length multi-cycle holds.
module hazard_stall_ctrl #(
  parameter int MC_LAT = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       if_id_Rn,
  input  logic [4:0]       if_id_Rm,
  input  logic             if_id_usesRm,
  input  logic             id_ex_memRead,
  input  logic [4:0]       id_ex_Rd,
  input  logic             br_taken,
  input  logic             mc_start,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MC_WAIT = 2'd1,
    MC_DONE = 2'd2
  } state_t;

  // The detection cycle already stalls once, so the wait counter covers MC_LAT-1 cycles.
  localparam logic [3:0] CNT_INIT = 4'(MC_LAT - 2);

  state_t     state_reg, state_next;
  logic [3:0] cnt_reg, cnt_next;
  logic       lu;

  // X31 reads as zero, so a load targeting it can never feed a consumer.
  always_comb begin
    lu = id_ex_memRead && (id_ex_Rd != 5'd31) &&
         ((id_ex_Rd == if_id_Rn) || (if_id_usesRm && (id_ex_Rd == if_id_Rm)));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= RUN;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      RUN: begin
        if (mc_start) begin
          state_next = MC_WAIT;
          cnt_next   = CNT_INIT;
        end
      end
      MC_WAIT: begin
        if (cnt_reg != 4'd0) cnt_next = cnt_reg - 4'd1;
        else                 state_next = MC_DONE;
      end
      MC_DONE: begin
        // The MUL that triggered the wait is still in ID, so mc_start is masked here.
        if (!lu) state_next = RUN;
      end
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    if (reset) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else begin
      case (state_reg)
        RUN: begin
          if (mc_start || lu) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
          end else if (br_taken) begin
            if_id_flush = 1'b1;
          end
        end
        MC_WAIT: begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
        end
        MC_DONE: begin
          if (lu) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
          end else if (br_taken) begin
            if_id_flush = 1'b1;
          end
        end
        default: begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
        end
      endcase
    end
  end

  // Index 0 counts stalled cycles, index 1 counts flush cycles; both stick at all-ones.
  logic [1:0] perf_inc;
  assign perf_inc = {if_id_flush, ~pc_write};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_perf
      logic [CNT_W-1:0] count_reg;
      always_ff @(posedge clk) begin
        if (reset)
          count_reg <= '0;
        else if (perf_inc[gi] && (count_reg != {CNT_W{1'b1}}))
          count_reg <= count_reg + 1'b1;
      end
    end
  endgenerate

  assign stall_cycles = g_perf[0].count_reg;
  assign flush_count  = g_perf[1].count_reg;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: a default instance plus a 3-bit-counter
// instance driven by the same stimulus to exercise counter saturation.
module tb_hazard_stall_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] if_id_Rn, if_id_Rm, id_ex_Rd;
  logic       if_id_usesRm, id_ex_memRead, br_taken, mc_start;

  logic        pc_write, if_id_write, if_id_flush, id_ex_bubble;
  logic [15:0] stall_cycles, flush_count;
  logic        s_pc_write, s_if_id_write, s_if_id_flush, s_id_ex_bubble;
  logic [2:0]  s_stall_cycles, s_flush_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.MC_LAT(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .if_id_Rn(if_id_Rn), .if_id_Rm(if_id_Rm), .if_id_usesRm(if_id_usesRm),
    .id_ex_memRead(id_ex_memRead), .id_ex_Rd(id_ex_Rd),
    .br_taken(br_taken), .mc_start(mc_start),
    .pc_write(pc_write), .if_id_write(if_id_write),
    .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  hazard_stall_ctrl #(.MC_LAT(4), .CNT_W(3)) dut_s (
    .clk(clk), .reset(reset),
    .if_id_Rn(if_id_Rn), .if_id_Rm(if_id_Rm), .if_id_usesRm(if_id_usesRm),
    .id_ex_memRead(id_ex_memRead), .id_ex_Rd(id_ex_Rd),
    .br_taken(br_taken), .mc_start(mc_start),
    .pc_write(s_pc_write), .if_id_write(s_if_id_write),
    .if_id_flush(s_if_id_flush), .id_ex_bubble(s_id_ex_bubble),
    .stall_cycles(s_stall_cycles), .flush_count(s_flush_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Control outputs packed as {pc_write, if_id_write, if_id_flush, id_ex_bubble}.
  task automatic chk_ctl(input string tag, input logic [3:0] exp);
    chk(tag, {28'd0, pc_write, if_id_write, if_id_flush, id_ex_bubble}, {28'd0, exp});
    $display("step %-12s ctl=%b exp=%b stall=%0d flush=%0d", tag,
             {pc_write, if_id_write, if_id_flush, id_ex_bubble}, exp, stall_cycles, flush_count);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_ex_memRead = 1'b0; id_ex_Rd = 5'd0; if_id_Rn = 5'd1; if_id_Rm = 5'd2;
    if_id_usesRm = 1'b0; br_taken = 1'b0; mc_start = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle();

    // Reset held for two cycles.
    tick();
    chk_ctl("rst_ctl1", 4'b0011);
    tick();
    chk_ctl("rst_ctl2", 4'b0011);
    chk("rst_stall", {16'd0, stall_cycles}, 32'd0);
    chk("rst_flush", {16'd0, flush_count}, 32'd0);
    reset = 1'b0;
    #1 chk_ctl("post_rst", 4'b1100);
    tick();
    chk("post_rst_cnt", {16'd0, stall_cycles}, 32'd0);

    // Single load-use stall on Rn.
    id_ex_memRead = 1'b1; id_ex_Rd = 5'd7; if_id_Rn = 5'd7;
    #1 chk_ctl("lu_rn", 4'b0001);
    tick();
    idle();
    #1 chk_ctl("lu_release", 4'b1100);
    tick();
    chk("lu_stall_cnt", {16'd0, stall_cycles}, 32'd1);

    // XZR never hazards; Rm only counts when usesRm.
    id_ex_memRead = 1'b1; id_ex_Rd = 5'd31; if_id_Rn = 5'd31;
    #1 chk_ctl("xzr", 4'b1100);
    id_ex_Rd = 5'd5; if_id_Rn = 5'd0; if_id_Rm = 5'd5; if_id_usesRm = 1'b0;
    #1 chk_ctl("rm_unused", 4'b1100);
    if_id_usesRm = 1'b1;
    #1 chk_ctl("rm_used", 4'b0001);
    tick();
    idle();
    tick();
    chk("rm_stall_cnt", {16'd0, stall_cycles}, 32'd2);

    // Taken branch flushes; with a concurrent load-use the stall wins.
    br_taken = 1'b1;
    #1 chk_ctl("br", 4'b1110);
    tick();
    idle();
    #1 chk("br_flush_cnt", {16'd0, flush_count}, 32'd1);
    id_ex_memRead = 1'b1; id_ex_Rd = 5'd3; if_id_Rn = 5'd3; br_taken = 1'b1;
    #1 chk_ctl("br_lu", 4'b0001);
    tick();
    idle();
    #1 chk("br_lu_flush_cnt", {16'd0, flush_count}, 32'd1);
    chk("br_lu_stall_cnt", {16'd0, stall_cycles}, 32'd3);

    // Multi-cycle op with mc_start held: 4 stalls, then one release cycle.
    mc_start = 1'b1;
    #1 chk_ctl("mc_c1", 4'b0001);
    tick();
    br_taken = 1'b1;
    #1 chk_ctl("mc_c2_br", 4'b0001);
    tick();
    br_taken = 1'b0;
    #1 chk_ctl("mc_c3", 4'b0001);
    tick();
    chk_ctl("mc_c4", 4'b0001);
    tick();
    chk_ctl("mc_done", 4'b1100);
    tick();
    mc_start = 1'b0;
    #1 chk_ctl("mc_run", 4'b1100);
    chk("mc_stall_cnt", {16'd0, stall_cycles}, 32'd7);
    chk("mc_flush_cnt", {16'd0, flush_count}, 32'd1);

    // Reset during the second MC_WAIT cycle aborts the wait.
    mc_start = 1'b1;
    tick();
    tick();
    mc_start = 1'b0;
    reset = 1'b1;
    #1 chk_ctl("abort_rst", 4'b0011);
    tick();
    reset = 1'b0;
    #1 chk_ctl("abort_run", 4'b1100);
    chk("abort_stall", {16'd0, stall_cycles}, 32'd0);
    chk("abort_flush", {16'd0, flush_count}, 32'd0);
    tick();

    // Ten load-use stalls: the 3-bit counter saturates at 7.
    for (int i = 0; i < 10; i++) begin
      id_ex_memRead = 1'b1; id_ex_Rd = 5'd9; if_id_Rn = 5'd9;
      tick();
      idle();
      tick();
    end
    chk("sat_stall_16", {16'd0, stall_cycles}, 32'd10);
    chk("sat_stall_3", {29'd0, s_stall_cycles}, 32'd7);
    chk("sat_flush_3", {29'd0, s_flush_count}, 32'd0);
    $display("sat   stall16=%0d stall3=%0d", stall_cycles, s_stall_cycles);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
